// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-op operand resolver.
// Holds the FSM state type, the op-select encodings and the default sizing.
package logic_op_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_MAX_OBS = 15;

  localparam logic OP_AND = 1'b1;
  localparam logic OP_OR  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // A session closes on an explicit last flag or once the observation limit is reached.
  function automatic logic closes_session(input logic last, input logic [3:0] count,
                                          input int max_obs);
    return last || (count == 4'(max_obs));
  endfunction

endpackage

// File: rtl/logic_op_infer.sv
// Per-observation inference: which B bits one (op, a, result) triple reveals,
// what those bits are, and whether the triple is impossible for any B.
module logic_op_infer
  import logic_op_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] known,
  output logic [WIDTH-1:0] value,
  output logic             inconsistent
);

  // AND passes B through where a=1 and forces 0 elsewhere; OR passes B where a=0 and forces 1 elsewhere.
  always_comb begin
    known        = '0;
    value        = '0;
    inconsistent = 1'b0;
    if (op == OP_AND) begin
      known        = a;
      value        = result & a;
      inconsistent = |(result & ~a);
    end else begin
      known        = ~a;
      value        = result & ~a;
      inconsistent = |(~result & a);
    end
  end

endmodule

// File: rtl/logic_op_resolver.sv
// Accumulates observations of (a op b) = result over a session and emits the
// inferred operand B, which of its bits are determined, and a conflict flag.
module logic_op_resolver
  import logic_op_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MAX_OBS = DEFAULT_MAX_OBS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             x,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] result,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] b_mask,
  output logic             conflict,
  output logic             incomplete,
  output logic [3:0]       obs_count
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [3:0]       count_q, count_d;
  logic             sess_conflict_q, sess_conflict_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] b_mask_q, b_mask_d;
  logic             conflict_q, conflict_d;
  logic             incomplete_q, incomplete_d;
  logic [3:0]       obs_count_q, obs_count_d;

  logic [WIDTH-1:0] obs_known;
  logic [WIDTH-1:0] obs_value;
  logic             obs_inconsistent;

  logic             accept;
  logic             first_obs;
  logic [WIDTH-1:0] mask_nx;
  logic [WIDTH-1:0] val_nx;
  logic [3:0]       count_nx;
  logic             conflict_nx;

  logic_op_infer #(
    .WIDTH(WIDTH)
  ) u_infer (
    .op          (x),
    .a           (a),
    .result      (result),
    .known       (obs_known),
    .value       (obs_value),
    .inconsistent(obs_inconsistent)
  );

  // Observations are taken whenever a record is not waiting to be collected.
  assign in_ready = !rst && (state_q != EMIT);
  assign accept   = in_valid && in_ready;

  // Fold the current observation into the session; the first observation replaces stale state.
  always_comb begin
    first_obs   = (state_q == IDLE);
    mask_nx     = mask_q;
    val_nx      = val_q;
    count_nx    = count_q;
    conflict_nx = sess_conflict_q;
    if (first_obs) begin
      mask_nx     = obs_known;
      val_nx      = obs_value;
      count_nx    = 4'd1;
      conflict_nx = obs_inconsistent;
    end else begin
      mask_nx     = mask_q | obs_known;
      val_nx      = val_q | (obs_value & ~mask_q);
      count_nx    = count_q + 4'd1;
      conflict_nx = sess_conflict_q | obs_inconsistent
                    | (|(mask_q & obs_known & (val_q ^ obs_value)));
    end
  end

  // Next-state and registered-output selection for the IDLE/ACCUM/EMIT session flow.
  always_comb begin
    state_d         = state_q;
    mask_d          = mask_q;
    val_d           = val_q;
    count_d         = count_q;
    sess_conflict_d = sess_conflict_q;
    out_valid_d     = out_valid_q;
    b_d             = b_q;
    b_mask_d        = b_mask_q;
    conflict_d      = conflict_q;
    incomplete_d    = incomplete_q;
    obs_count_d     = obs_count_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          mask_d          = mask_nx;
          val_d           = val_nx;
          count_d         = count_nx;
          sess_conflict_d = conflict_nx;
          if (closes_session(in_last, count_nx, MAX_OBS)) begin
            state_d      = EMIT;
            out_valid_d  = 1'b1;
            b_d          = val_nx & mask_nx;
            b_mask_d     = mask_nx;
            conflict_d   = conflict_nx;
            incomplete_d = ~&mask_nx;
            obs_count_d  = count_nx;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Single state register; reset discards any open session or pending record.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      mask_q          <= '0;
      val_q           <= '0;
      count_q         <= '0;
      sess_conflict_q <= 1'b0;
      out_valid_q     <= 1'b0;
      b_q             <= '0;
      b_mask_q        <= '0;
      conflict_q      <= 1'b0;
      incomplete_q    <= 1'b0;
      obs_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      val_q           <= val_d;
      count_q         <= count_d;
      sess_conflict_q <= sess_conflict_d;
      out_valid_q     <= out_valid_d;
      b_q             <= b_d;
      b_mask_q        <= b_mask_d;
      conflict_q      <= conflict_d;
      incomplete_q    <= incomplete_d;
      obs_count_q     <= obs_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign b          = b_q;
  assign b_mask     = b_mask_q;
  assign conflict   = conflict_q;
  assign incomplete = incomplete_q;
  assign obs_count  = obs_count_q;

endmodule

// File: tb/tb_logic_op_resolver.sv
// Self-checking bench for logic_op_resolver: directed scenarios plus randomized
// sessions checked against a bit-level reasoning model of operand inference.
module tb_logic_op_resolver;

  localparam int W    = 8;
  localparam int MAXO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         x;
  logic [W-1:0] a;
  logic [W-1:0] result;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] b;
  logic [W-1:0] b_mask;
  logic         conflict;
  logic         incomplete;
  logic [3:0]   obs_count;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    bit           op;
    logic [W-1:0] av;
    logic [W-1:0] rv;
  } obs_t;

  obs_t sess[$];

  logic_op_resolver #(
    .WIDTH  (W),
    .MAX_OBS(MAXO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .a         (a),
    .result    (result),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b),
    .b_mask    (b_mask),
    .conflict  (conflict),
    .incomplete(incomplete),
    .obs_count (obs_count)
  );

  always #5 clk = ~clk;

  // Observed record: {out_valid, b, b_mask, conflict, incomplete, obs_count}
  function automatic logic [22:0] observed();
    return {out_valid, b, b_mask, conflict, incomplete, obs_count};
  endfunction

  // Reason about each bit of B independently: AND with a=1 / OR with a=0 reveals it,
  // otherwise the result bit is forced (0 for AND, 1 for OR) and must match that.
  function automatic logic [22:0] model_record();
    bit           known[W];
    bit           val[W];
    bit           bad;
    logic [W-1:0] eb;
    logic [W-1:0] em;
    bad = 0;
    eb  = '0;
    em  = '0;
    for (int i = 0; i < W; i++) begin
      known[i] = 0;
      val[i]   = 0;
    end
    foreach (sess[n]) begin
      for (int i = 0; i < W; i++) begin
        bit reveals;
        bit r;
        reveals = sess[n].op ? sess[n].av[i] : !sess[n].av[i];
        r       = sess[n].rv[i];
        if (!reveals) begin
          if (r != !sess[n].op) bad = 1;
        end else if (known[i]) begin
          if (val[i] != r) bad = 1;
        end else begin
          known[i] = 1;
          val[i]   = r;
        end
      end
    end
    for (int i = 0; i < W; i++) begin
      em[i] = known[i];
      eb[i] = known[i] && val[i];
    end
    return {1'b1, eb, em, bad, ~&em, 4'(sess.size())};
  endfunction

  task automatic send_obs(input bit op, input logic [W-1:0] av, input logic [W-1:0] rv,
                          input bit last);
    bit ok;
    obs_t o;
    x        = op;
    a        = av;
    result   = rv;
    in_last  = last;
    in_valid = 1'b1;
    ok       = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b, required 1 within 20 cycles", in_ready);
    end else begin
      o.op = op;
      o.av = av;
      o.rv = rv;
      sess.push_back(o);
    end
  endtask

  task automatic pop_record();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    sess.delete();
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    x        = 1'($urandom);
    a        = 8'($urandom);
    result   = 8'($urandom);
    in_last  = 1'b1;
    @(posedge clk);
    #1;
    in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = 1'b0; a = '0; result = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({observed(), in_ready} !== 24'h0) begin
      fails++;
      $display("[TB] FAIL reset_state: got %h, expected %h", {observed(), in_ready}, 24'h0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL reset_release: got %b, expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_single();
    sess.delete();
    send_obs(1'b1, 8'hFF, 8'h5A, 1'b1);
    checks++;
    if ({observed(), in_ready} !== {1'b1, 8'h5A, 8'hFF, 1'b0, 1'b0, 4'd1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL single_record: got %h, expected %h", {observed(), in_ready},
               {1'b1, 8'h5A, 8'hFF, 1'b0, 1'b0, 4'd1, 1'b0});
    end
    pop_record();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL single_pop: got %b, expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_merge();
    send_obs(1'b0, 8'hF0, 8'hF3, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL merge_early_valid: got %b, expected 0", out_valid);
    end
    send_obs(1'b1, 8'hF0, 8'h90, 1'b1);
    checks++;
    if (observed() !== {1'b1, 8'h93, 8'hFF, 1'b0, 1'b0, 4'd2}) begin
      fails++;
      $display("[TB] FAIL merge_record: got %h, expected %h", observed(),
               {1'b1, 8'h93, 8'hFF, 1'b0, 1'b0, 4'd2});
    end
    pop_record();
  endtask

  task automatic test_inconsistent();
    send_obs(1'b1, 8'h0F, 8'h10, 1'b1);
    checks++;
    if (observed() !== {1'b1, 8'h00, 8'h0F, 1'b1, 1'b1, 4'd1}) begin
      fails++;
      $display("[TB] FAIL inconsistent_record: got %h, expected %h", observed(),
               {1'b1, 8'h00, 8'h0F, 1'b1, 1'b1, 4'd1});
    end
    pop_record();
  endtask

  task automatic test_cross_conflict();
    send_obs(1'b1, 8'hFF, 8'h01, 1'b0);
    send_obs(1'b0, 8'h00, 8'h00, 1'b1);
    checks++;
    if (observed() !== {1'b1, 8'h01, 8'hFF, 1'b1, 1'b0, 4'd2}) begin
      fails++;
      $display("[TB] FAIL cross_conflict_record: got %h, expected %h", observed(),
               {1'b1, 8'h01, 8'hFF, 1'b1, 1'b0, 4'd2});
    end
    pop_record();
  endtask

  task automatic test_backpressure();
    logic [22:0] exp_rec;
    exp_rec = {1'b1, 8'hC3, 8'hFF, 1'b0, 1'b0, 4'd1};
    send_obs(1'b1, 8'hFF, 8'hC3, 1'b1);
    x = 1'b1; a = 8'hFF; result = 8'h00; in_last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({observed(), in_ready} !== {exp_rec, 1'b0}) begin
        fails++;
        $display("[TB] FAIL backpressure_hold_%0d: got %h, expected %h", c,
                 {observed(), in_ready}, {exp_rec, 1'b0});
      end
      @(posedge clk);
      #1;
    end
    pop_record();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL backpressure_release: got %b, expected 01", {out_valid, in_ready});
    end
    send_obs(1'b1, 8'hFF, 8'h11, 1'b1);
    checks++;
    if (observed() !== {1'b1, 8'h11, 8'hFF, 1'b0, 1'b0, 4'd1}) begin
      fails++;
      $display("[TB] FAIL backpressure_no_leak: got %h, expected %h", observed(),
               {1'b1, 8'h11, 8'hFF, 1'b0, 1'b0, 4'd1});
    end
    pop_record();
  endtask

  task automatic test_idle_gaps();
    send_obs(1'b1, 8'hF0, 8'hA0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      idle_cycle();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        fails++;
        $display("[TB] FAIL gap_idle_%0d: got %b, expected 01", c, {out_valid, in_ready});
      end
    end
    send_obs(1'b0, 8'hF0, 8'hF5, 1'b1);
    checks++;
    if (observed() !== {1'b1, 8'hA5, 8'hFF, 1'b0, 1'b0, 4'd2}) begin
      fails++;
      $display("[TB] FAIL gap_record: got %h, expected %h", observed(),
               {1'b1, 8'hA5, 8'hFF, 1'b0, 1'b0, 4'd2});
    end
    pop_record();
  endtask

  task automatic test_limit_reset();
    for (int i = 0; i < MAXO; i++) begin
      send_obs(1'b0, 8'hFF, 8'hFF, 1'b0);
      if (i == MAXO - 2) begin
        checks++;
        if (out_valid !== 1'b0) begin
          fails++;
          $display("[TB] FAIL limit_early_close: got %b, expected 0", out_valid);
        end
      end
    end
    checks++;
    if (observed() !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 4'd15}) begin
      fails++;
      $display("[TB] FAIL limit_record: got %h, expected %h", observed(),
               {1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 4'd15});
    end
    pop_record();
    for (int i = 0; i < 3; i++) send_obs(1'b1, 8'hFF, 8'hAA, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({observed(), in_ready} !== 24'h0) begin
      fails++;
      $display("[TB] FAIL reset_mid_session: got %h, expected %h", {observed(), in_ready}, 24'h0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL reset_mid_idle: got %b, expected 01", {out_valid, in_ready});
    end
    sess.delete();
    send_obs(1'b1, 8'hFF, 8'h3C, 1'b1);
    checks++;
    if (observed() !== {1'b1, 8'h3C, 8'hFF, 1'b0, 1'b0, 4'd1}) begin
      fails++;
      $display("[TB] FAIL reset_fresh_session: got %h, expected %h", observed(),
               {1'b1, 8'h3C, 8'hFF, 1'b0, 1'b0, 4'd1});
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL reset_in_emit: got %b, expected 01", {out_valid, in_ready});
    end
    sess.delete();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v;
    out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      v = 8'($urandom);
      send_obs(1'b1, 8'hFF, v, 1'b1);
      checks++;
      if (observed() !== {1'b1, v, 8'hFF, 1'b0, 1'b0, 4'd1}) begin
        fails++;
        $display("[TB] FAIL b2b_record_%0d: got %h, expected %h", s, observed(),
                 {1'b1, v, 8'hFF, 1'b0, 1'b0, 4'd1});
      end
      @(posedge clk);
      #1;
      sess.delete();
    end
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL b2b_idle: got %b, expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_random();
    int           len;
    int           hold;
    bit           op;
    bit           last;
    logic [W-1:0] hb;
    logic [W-1:0] av;
    logic [W-1:0] rv;
    logic [22:0]  exp_rec;
    for (int s = 0; s < 40; s++) begin
      sess.delete();
      len = $urandom_range(1, MAXO);
      hb  = 8'($urandom);
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 2)) idle_cycle();
        op = 1'($urandom);
        av = 8'($urandom);
        rv = op ? (av & hb) : (av | hb);
        if ($urandom_range(0, 9) == 0) rv = rv ^ 8'(1 << $urandom_range(0, 7));
        last = (j == len - 1) && ((len < MAXO) || ($urandom_range(0, 1) == 1));
        send_obs(op, av, rv, last);
      end
      exp_rec = model_record();
      hold = $urandom_range(0, 3);
      for (int c = 0; c <= hold; c++) begin
        checks++;
        if ({observed(), in_ready} !== {exp_rec, 1'b0}) begin
          fails++;
          $display("[TB] FAIL random_s%0d_c%0d: got %h, expected %h", s, c,
                   {observed(), in_ready}, {exp_rec, 1'b0});
        end
        if (c < hold) begin
          @(posedge clk);
          #1;
        end
      end
      pop_record();
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL random_pop_s%0d: got %b, expected 0", s, out_valid);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_merge();
    test_inconsistent();
    test_cross_conflict();
    test_backpressure();
    test_idle_gaps();
    test_limit_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
